fetch_sequencer: RTL and testbench

//  Fetch-stage controller that sequences the Program_Counter register. Owns the instruction-memory

---
 rtl/fetch_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences the PC, owns the imem handshake, buffers the word.
// Optional trap entry (trap/epc ports, TRAP_VECTOR) when FETCH_TRAP_EN is defined.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_INC       = 4
`ifdef FETCH_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr,
    output logic        fetch_valid,
    output logic        align_fault
`ifdef FETCH_TRAP_EN
    ,
    input  logic        trap,
    output logic [31:0] epc
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        FLUSH,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] redir_latch;
    logic [31:0] latch_n;
    logic        redir;
    logic        is_trap;
    logic [31:0] tgt;
    logic        misalign;
    logic        capture;
    logic        fv_n;
    logic        fault_set;
    logic        accept;
    logic [31:0] pc_inc;

    assign imem_addr = pc_current;
    assign pc_inc    = pc_current + PC_INC;
    assign misalign  = redir && (tgt[1:0] != 2'b00);

    // Pick the winning redirect request: trap > jump > branch.
    always_comb begin
        redir   = jump | branch_taken;
        tgt     = jump ? jump_target : branch_target;
        is_trap = 1'b0;
`ifdef FETCH_TRAP_EN
        if (trap) begin
            redir   = 1'b1;
            tgt     = TRAP_VECTOR;
            is_trap = 1'b1;
        end
`endif
    end

    // Next-state, PC control and buffer-update decisions.
    always_comb begin
        state_n   = state;
        pc_write  = 1'b0;
        pc_next   = RESET_VECTOR;
        imem_req  = 1'b0;
        capture   = 1'b0;
        fv_n      = fetch_valid;
        fault_set = 1'b0;
        latch_n   = redir_latch;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                fv_n    = 1'b0;
                state_n = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redir) begin
                    accept = 1'b1;
                    fv_n   = 1'b0;
                    if (misalign) begin
                        fault_set = 1'b1;
                        state_n   = FAULT;
                    end else if (imem_ack) begin
                        pc_write = 1'b1;
                        pc_next  = tgt;
                    end else begin
                        latch_n = tgt;
                        state_n = FLUSH;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        capture  = 1'b1;
                        fv_n     = 1'b1;
                        pc_write = 1'b1;
                        pc_next  = pc_inc;
                    end else if (!fetch_valid) begin
                        capture = 1'b1;
                        fv_n    = 1'b1;
                        state_n = HOLD;
                    end
                    // Older word still waiting: drop this one, PC
                    // is not advanced so the same address is refetched.
                end else begin
                    fv_n = fetch_valid & stall;
                end
            end
            HOLD: begin
                if (redir) begin
                    accept = 1'b1;
                    fv_n   = 1'b0;
                    if (misalign) begin
                        fault_set = 1'b1;
                        state_n   = FAULT;
                    end else begin
                        pc_write = 1'b1;
                        pc_next  = tgt;
                        state_n  = FETCH;
                    end
                end else if (!stall) begin
                    pc_write = 1'b1;
                    pc_next  = pc_inc;
                    fv_n     = 1'b0;
                    state_n  = FETCH;
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                fv_n     = 1'b0;
                accept   = redir;
                if (misalign) begin
                    fault_set = 1'b1;
                    state_n   = FAULT;
                end else if (imem_ack) begin
                    pc_write = 1'b1;
                    pc_next  = redir ? tgt : redir_latch;
                    state_n  = FETCH;
                end else if (redir) begin
                    latch_n = tgt;
                end
            end
            FAULT: begin
                fv_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Instruction buffer, valid flag, sticky fault and redirect latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= 32'h0;
            fetch_valid <= 1'b0;
            align_fault <= 1'b0;
            redir_latch <= 32'h0;
        end else begin
            if (capture) instr <= imem_rdata;
            fetch_valid <= fv_n;
            align_fault <= align_fault | fault_set;
            redir_latch <= latch_n;
        end
    end

`ifdef FETCH_TRAP_EN
    // Record the interrupted PC when a trap is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  epc <= 32'h0;
        else if (accept && is_trap) epc <= pc_current;
    end
`else
    logic unused_accept;
    assign unused_accept = accept | is_trap;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic
// checked against a program-order instruction-stream scoreboard.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] instr;
    logic        fetch_valid;
    logic        align_fault;
`ifdef FETCH_TRAP_EN
    logic        trap = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] epc;
`endif

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc = 32'h0;

    fetch_sequencer dut (
        .clk(clk),
        .reset(reset),
        .pc_current(pc_current),
        .pc_next(pc_next),
        .pc_write(pc_write),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .instr(instr),
        .fetch_valid(fetch_valid),
        .align_fault(align_fault)
`ifdef FETCH_TRAP_EN
        ,
        .trap(trap),
        .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    // Program_Counter register model.
    always @(posedge clk or posedge reset) begin
        if (reset)         pc_current <= 32'h0;
        else if (pc_write) pc_current <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic sb_redirect(input logic [31:0] t);
        exp_q.delete();
        exp_pc = t;
        refill();
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic step(input bit ack, input bit stl,
                        input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt);
        @(negedge clk);
        imem_ack      = ack & imem_req;
        imem_rdata    = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        stall         = stl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
`ifdef FETCH_TRAP_EN
        trap = trap_req;
        if (trap_req) sb_redirect(32'h0000_0100);
        else if (br | jp) sb_redirect(jp ? jt : bt);
`else
        if (br | jp) sb_redirect(jp ? jt : bt);
`endif
        refill();
    endtask

    task automatic rst_checks();
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc_write", {31'b0, pc_write}, 32'h0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_align_fault", {31'b0, align_fault}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        sb_redirect(32'h0);
        #1;
        rst_checks();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever IF/ID takes a word.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (imem_req) chk("imem_addr", imem_addr, pc_current);
            if (fetch_valid && !stall && !branch_taken && !jump
`ifdef FETCH_TRAP_EN
                && !trap
`endif
                ) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got %h expected none", instr);
                end else begin
                    chk("instr_stream", instr, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        do_reset();

        // Sequential fetch, one ack per cycle.
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_pcnext0", pc_next, 32'h4);
        chk("t1_fv0", {31'b0, fetch_valid}, 32'h0);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_fv1", {31'b0, fetch_valid}, 32'h1);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_instr2", instr, mem_word(32'h4));

        // Stalled ack parks in HOLD with the PC frozen.
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); #1;
        chk("t2_nowrite", {31'b0, pc_write}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0); #1;
            chk("t2_req", {31'b0, imem_req}, 32'h0);
            chk("t2_pc", pc_current, 32'hC);
            chk("t2_instr", instr, mem_word(32'hC));
        end
        step(0, 0, 0, 0, 0, 0); #1;
        chk("t2_rel_pcnext", pc_next, 32'h10);
        step(0, 0, 0, 0, 0, 0); #1;
        chk("t2_rel_addr", imem_addr, 32'h10);

        // Branch while a request is pending: old word discarded.
        step(0, 0, 1, 32'h40, 0, 0);
        step(0, 0, 0, 0, 0, 0); #1;
        chk("t3_old_addr", imem_addr, 32'h10);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t3_pcnext", pc_next, 32'h40);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t3_new_addr", imem_addr, 32'h40);
        chk("t3_fv", {31'b0, fetch_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0); #1;
        chk("t3_instr", instr, mem_word(32'h40));

        // Jump beats branch; misaligned jump faults.
        step(1, 0, 1, 32'h40, 1, 32'h80); #1;
        chk("t4_pcnext", pc_next, 32'h80);
        step(0, 0, 0, 0, 0, 0); #1;
        chk("t4_addr", imem_addr, 32'h80);
        step(0, 0, 0, 0, 1, 32'h82); #1;
        chk("t4_nowrite", {31'b0, pc_write}, 32'h0);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t4_fault", {31'b0, align_fault}, 32'h1);
        chk("t4_req", {31'b0, imem_req}, 32'h0);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t4_sticky", {31'b0, align_fault}, 32'h1);
        chk("t4_fv", {31'b0, fetch_valid}, 32'h0);

        // PC wrap, then reset in the middle of a request.
        do_reset();
        step(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t5_pcnext_f8", pc_next, 32'hFFFF_FFF8);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t5_addr_fc", imem_addr, 32'hFFFF_FFFC);
        chk("t5_wrap", pc_next, 32'h0);
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t5_addr_0", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        rst_checks();

`ifdef FETCH_TRAP_EN
        // Trap wins over jump and records the PC.
        do_reset();
        step(0, 0, 0, 0, 1, 32'h20);
        step(1, 0, 0, 0, 0, 0);
        trap_req = 1'b1;
        step(0, 0, 0, 0, 1, 32'h80);
        trap_req = 1'b0;
        step(1, 0, 0, 0, 0, 0); #1;
        chk("t6_pcnext", pc_next, 32'h100);
        chk("t6_epc", epc, 32'h20);
`endif

        // Random traffic against the instruction-stream scoreboard.
        do_reset();
        consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            t = ($urandom % 8 == 0) ? 32'hFFFF_FFF0
                                    : ($urandom & 32'h0000_0FFC);
            step(($urandom % 4) != 0, ($urandom % 3) == 0,
                 ($urandom % 16) == 0, t,
                 ($urandom % 20) == 0, t + 32'h100);
        end
        @(negedge clk);
        #3;
        chk("rnd_progress", {31'b0, consumed > 300}, 32'h1);
        chk("rnd_no_fault", {31'b0, align_fault}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
